// File: rtl/gfx_pkg.sv
// gfx_pkg: shared constants and types for the 1bpp 320x200 frame-buffer path.
//   FRAME_WIDTH / FRAME_HEIGHT : source raster size in pixels / rows
//   COLOR_CELLS_X              : bytes per source row (8 pixels per byte)
//   FB_ADDR_W                  : frame buffer byte address width
//   fetch_state_t              : scanout fetch FSM states
//   fb_byte_addr()             : row*40+col without a multiplier
package gfx_pkg;

    localparam int FRAME_WIDTH   = 320;
    localparam int FRAME_HEIGHT  = 200;
    localparam int COLOR_CELLS_X = 40;
    localparam int FB_ADDR_W     = 14;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WAIT,
        DONE
    } fetch_state_t;

    // row*40 = (row<<5) + (row<<3); max 199*40+39 = 7999 fits in 14 bits.
    function automatic logic [FB_ADDR_W-1:0] fb_byte_addr(input logic [7:0] row,
                                                          input logic [5:0] col);
        logic [FB_ADDR_W-1:0] r;
        r = {6'd0, row};
        return (r << 5) + (r << 3) + {8'd0, col};
    endfunction

endpackage

// File: rtl/fb_byte_fifo.sv
// fb_byte_fifo: 2-entry, 8-bit prefetch FIFO between the frame buffer fetch and
// the pixel serialiser. pop_data shows the head entry combinationally so the
// serialiser can use a byte in the same cycle it pops it.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear (wins over push/pop)
//   push/push_data : write one byte; accepted when not full or popping
//   pop/pop_data : remove head byte; ignored when empty
//   full/empty   : occupancy flags
module fb_byte_fifo (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    logic [7:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // A push on a full FIFO is legal only alongside a pop (occupancy unchanged).
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (do_pop && !do_push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: read side of the 1bpp frame buffer. Fetches 40-byte source
// rows and serialises them (bit 0 = leftmost pixel) into the VGA pixel stream
// with H_REPEAT horizontal and V_REPEAT vertical pixel repeat.
//   clk, reset_n   : clock, asynchronous active-low reset
//   frame_start    : next line_start is source row 0
//   line_start     : start prefetch for the next display line (aborts any line in flight)
//   pixel_req      : VGA consumes one pixel; pixel_out/pixel_valid update 1 clk later
//   fb_addr, fb_read_en, fb_read_data : frame buffer read port (data 1 clk after strobe)
//   pixel_out, pixel_valid : pixel value and whether it came from fetched data
//   underrun       : sticky, pixel requested with nothing fetched; cleared by frame_start
//   line_active    : a source row is being fetched/serialised
//
// state   | meaning
// IDLE    | no row in progress (blank line, or row fully drained)
// ISSUE   | fb_read_en high for one clk, fb_addr = row*40+col
// CAPTURE | read data valid, pushed into the FIFO
// WAIT    | FIFO full, waiting for the serialiser to free a slot
// DONE    | all 40 bytes fetched, waiting for the serialiser to drain the line
module fb_scanout_reader
    import gfx_pkg::*;
#(
    parameter int H_REPEAT = 2,
    parameter int V_REPEAT = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 line_start,
    input  logic                 pixel_req,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic                 fb_read_en,
    input  logic [7:0]           fb_read_data,
    output logic                 pixel_out,
    output logic                 pixel_valid,
    output logic                 underrun,
    output logic                 line_active
);

    localparam int HREP_W = (H_REPEAT > 1) ? $clog2(H_REPEAT) : 1;
    localparam int VREP_W = (V_REPEAT > 1) ? $clog2(V_REPEAT) : 1;
    localparam logic [15:0] PIX_PER_LINE = 16'(FRAME_WIDTH * H_REPEAT);

    fetch_state_t      state;
    logic [7:0]        row, row_n, base_row;
    logic [VREP_W-1:0] vrep, vrep_n, base_vrep;
    logic              first_line, first_n, base_first;
    logic              line_ok;
    logic [5:0]        col;
    logic [15:0]       pix_left;

    logic [7:0]        sr;
    logic              sr_valid;
    logic [2:0]        bit_idx;
    logic [HREP_W-1:0] hrep;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_data;
    logic              in_line, byte_avail, hrep_wrap, byte_end;
    logic [7:0]        cur_byte;

    // frame_start is folded in before line_start so both in one cycle start row 0.
    always_comb begin
        base_row   = frame_start ? 8'd0 : row;
        base_vrep  = frame_start ? '0 : vrep;
        base_first = frame_start | first_line;
        row_n      = base_row;
        vrep_n     = base_vrep;
        first_n    = base_first;
        if (line_start) begin
            if (base_first) begin
                first_n = 1'b0;
            end else if (base_vrep == VREP_W'(V_REPEAT - 1)) begin
                vrep_n = '0;
                // Saturate past the last row so a long frame cannot wrap back to row 0.
                if (base_row < 8'(FRAME_HEIGHT)) begin
                    row_n = base_row + 8'd1;
                end
            end else begin
                vrep_n = base_vrep + VREP_W'(1);
            end
        end
    end

    assign line_ok    = (row_n < 8'(FRAME_HEIGHT));
    assign in_line    = (pix_left != 16'd0);
    assign byte_avail = sr_valid || !fifo_empty;
    // When the shift register is empty the FIFO head feeds the output directly (no bubble).
    assign cur_byte   = sr_valid ? sr : fifo_data;
    assign hrep_wrap  = (hrep == HREP_W'(H_REPEAT - 1));
    assign byte_end   = hrep_wrap && (bit_idx == 3'd7);
    assign fifo_pop   = pixel_req && !line_start && in_line && !sr_valid && !fifo_empty;
    assign fifo_push  = (state == CAPTURE) && !line_start && in_line;

    fb_byte_fifo u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (line_start),
        .push      (fifo_push),
        .push_data (fb_read_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            row         <= 8'd0;
            vrep        <= '0;
            first_line  <= 1'b1;
            col         <= 6'd0;
            pix_left    <= 16'd0;
            sr          <= 8'd0;
            sr_valid    <= 1'b0;
            bit_idx     <= 3'd0;
            hrep        <= '0;
            fb_addr     <= '0;
            fb_read_en  <= 1'b0;
            pixel_out   <= 1'b0;
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;
            line_active <= 1'b0;
        end else begin
            row        <= row_n;
            vrep       <= vrep_n;
            first_line <= first_n;

            if (line_start) begin
                // Abort whatever was in flight; the FIFO flushes on the same edge.
                col         <= 6'd0;
                sr_valid    <= 1'b0;
                bit_idx     <= 3'd0;
                hrep        <= '0;
                pixel_out   <= 1'b0;
                pixel_valid <= 1'b0;
                if (line_ok) begin
                    state       <= ISSUE;
                    fb_read_en  <= 1'b1;
                    fb_addr     <= fb_byte_addr(row_n, 6'd0);
                    pix_left    <= PIX_PER_LINE;
                    line_active <= 1'b1;
                end else begin
                    state       <= IDLE;
                    fb_read_en  <= 1'b0;
                    pix_left    <= 16'd0;
                    line_active <= 1'b0;
                end
            end else begin
                if (pixel_req) begin
                    if (!in_line) begin
                        pixel_out   <= 1'b0;
                        pixel_valid <= 1'b0;
                    end else begin
                        pix_left <= pix_left - 16'd1;
                        if (byte_avail) begin
                            pixel_out   <= cur_byte[bit_idx];
                            pixel_valid <= 1'b1;
                        end else begin
                            pixel_out   <= 1'b0;
                            pixel_valid <= 1'b0;
                            underrun    <= 1'b1;
                        end
                        if (fifo_pop) begin
                            sr <= fifo_data;
                        end
                        sr_valid <= (sr_valid | fifo_pop) & ~byte_end;
                        // Position advances even on underrun to stay in step with VGA timing.
                        if (hrep_wrap) begin
                            hrep    <= '0;
                            bit_idx <= bit_idx + 3'd1;
                        end else begin
                            hrep <= hrep + HREP_W'(1);
                        end
                    end
                end

                // Once every pixel of the line has been consumed nothing further is useful.
                if (state != IDLE && !in_line) begin
                    state       <= IDLE;
                    fb_read_en  <= 1'b0;
                    line_active <= 1'b0;
                end else begin
                    case (state)
                        ISSUE: begin
                            fb_read_en <= 1'b0;
                            state      <= CAPTURE;
                        end
                        CAPTURE: begin
                            col <= col + 6'd1;
                            if (col == 6'(COLOR_CELLS_X - 1)) begin
                                state <= DONE;
                            end else if (fifo_empty || fifo_pop) begin
                                state      <= ISSUE;
                                fb_read_en <= 1'b1;
                                fb_addr    <= fb_byte_addr(row, col + 6'd1);
                            end else begin
                                state <= WAIT;
                            end
                        end
                        WAIT: begin
                            if (!fifo_full || fifo_pop) begin
                                state      <= ISSUE;
                                fb_read_en <= 1'b1;
                                fb_addr    <= fb_byte_addr(row, col);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            if (frame_start) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule
